ld_align_unit: RTL and testbench
================================

Name: ld_align_unit

Overview:
Parametrised load-data unit and successor to the combinational load converter. It accepts one load request at a time and issues one or two word-aligned memory reads. It merges the beats when an access straddles a word boundary, then sign- or zero-extends the selected bytes. It sits between the core's memory-access stage and the data bus, and returns a registered result with a valid strobe.

Parameters:
XLEN, 32, data and bus width in bits; legal values 32 or 64.
AW, 32, byte-address width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  load request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_addr  input  AW  byte address of the load.
ir  input  32  instruction register; ir[14:12] selects the load type.
mem_rd  output  1  read strobe; held high until mem_rvalid.
mem_addr  output  AW  word-aligned byte address of the current beat.
mem_rvalid  input  1  mem_rdata is valid this cycle.
mem_rdata  input  XLEN  read data, little-endian.
out_valid  output  1  one-cycle pulse; out_data and out_fault are valid.
out_data  output  XLEN  converted load result.
out_fault  output  1  illegal load type; qualified by out_valid.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. Outputs: req_ready=1, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_fault=0. All internal registers are cleared.
- Load type from ir[14:12]:
  - 000 LB, 1 byte, signed; 100 LBU, 1 byte, unsigned.
  - 001 LH, 2 bytes, signed; 101 LHU, 2 bytes, unsigned.
  - 010 LW, 4 bytes; signed when XLEN=64, otherwise passed through.
  - 011 LD, 8 bytes, XLEN=64 only; 110 LWU, 4 bytes unsigned, XLEN=64 only.
  - 111, and 011/110 when XLEN=32, are illegal.
- Definitions: NB=XLEN/8 bytes per word; off=req_addr[log2(NB)-1:0]; base=req_addr with the low log2(NB) bits cleared; split = (off+size > NB).
- Accept: a request is taken when req_valid && req_ready. Addr, off, type and split are captured in that cycle.
- FSM states: IDLE, RD0, RD1, RESP.
- IDLE -> RD0 on accept of a legal type. IDLE -> RESP on accept of an illegal type; no memory access is made.
- RD0: mem_rd=1, mem_addr=base.
  - On mem_rvalid, store the beat in lo.
  - Go to RD1 if split, else to RESP.
- RD1: mem_rd=1, mem_addr = base+NB, wrapping modulo 2^AW.
  - On mem_rvalid, store the beat in hi and go to RESP.
- RESP: out_valid=1 for exactly one cycle, then go to IDLE. out_data and out_fault hold their values until the next RESP or reset.
- Merge rule: window = {hi, lo} >> (8*off); take the low size bytes; sign-extend (signed types) or zero-fill (unsigned) to XLEN. hi is treated as 0 when the access is not split.
- Illegal type: out_fault=1 and out_data=0. A legal type gives out_fault=0.
- Latency: with mem_rvalid returned in the first cycle of mem_rd, the accept cycle is N and out_valid is high at N+2 (unsplit) or N+3 (split). Wait states extend this one cycle each.
- mem_rvalid in IDLE or RESP is ignored. mem_rdata is sampled only when mem_rvalid=1 in RD0 or RD1.
- req_ready=0 outside IDLE. A new request arriving in RESP is not taken until the following cycle in IDLE, so the minimum spacing is one idle cycle.
- Reset asserted mid-operation: the load is abandoned, no out_valid is produced, and mem_rd drops immediately.
- mem_addr is only meaningful while mem_rd=1; it holds its last value otherwise.

Test Plan:
- XLEN=32. LB (ir[14:12]=000), addr 0x103, beat 0x80112233 -> one read at 0x100; out_data=0xFFFFFF80, out_fault=0, out_valid at accept+2.
- XLEN=32. LHU (101), addr 0x103, beats 0xAABBCCDD then 0x11223344 -> reads at 0x100 then 0x104; out_data=0x000044AA, out_valid at accept+3.
- XLEN=32. LW (010), addr 0x200, beat 0xDEADBEEF, mem_rvalid delayed 3 cycles -> mem_rd held high for 3 cycles; out_data=0xDEADBEEF; a single out_valid pulse; req_ready=0 throughout.
- XLEN=32. ir[14:12]=111 -> no mem_rd; out_valid at accept+1 with out_fault=1, out_data=0. Repeat with 011 -> same response.
- XLEN=64. LD (011), addr 0x...FFFC with AW=32, beats 0x0706050403020100 then 0x0F0E0D0C0B0A0908 -> second read wraps to address 0; out_data=0x0B0A090807060504.
- Reset pulled low during RD1 of a split LH -> mem_rd=0 and state IDLE immediately; no out_valid. A subsequent aligned LH at 0x102 with beat 0x8001ABCD returns 0xFFFF8001.

Source files
------------

// File: rtl/ld_align_unit.sv
// Load-data unit: one or two word-aligned reads per load, beat merge, sign/zero extension.
// Latency: accept N -> out_valid at N+2 (one beat) or N+3 (two beats), +1 per memory wait cycle; illegal type N+1.
// Backpressure: req_ready only in IDLE; mem_rd held until mem_rvalid; out_valid is a one-cycle pulse (no stall).
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   req_valid/ready     load request handshake; req_addr byte address, ir[14:12] load type
//   mem_rd/mem_addr     read strobe and word-aligned beat address
//   mem_rvalid/rdata    read data return (little-endian)
//   out_valid/data/fault  registered result, fault flags an illegal load type
module ld_align_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [31:0]     ir,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic            out_fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t state_q, state_d;

  // Captured request
  logic [OW-1:0]   off_q;
  logic [3:0]      size_q;
  logic            sgn_q;
  logic            split_q;
  logic [XLEN-1:0] lo_q;

  // Request decode (combinational, used only in the accept cycle)
  logic [3:0]    dec_size;
  logic          dec_sgn;
  logic          dec_legal;
  logic [OW-1:0] req_off;
  logic [AW-1:0] req_base;
  logic [4:0]    req_span;
  logic          req_split;

  // Only the funct3 field of the instruction matters here.
  logic unused_ir;
  assign unused_ir = ^{ir[31:15], ir[11:0]};

  always_comb begin
    dec_size  = 4'd0;
    dec_sgn   = 1'b0;
    dec_legal = 1'b0;
    case (ir[14:12])
      3'b000: begin dec_size = 4'd1; dec_sgn = 1'b1; dec_legal = 1'b1; end
      3'b100: begin dec_size = 4'd1; dec_legal = 1'b1; end
      3'b001: begin dec_size = 4'd2; dec_sgn = 1'b1; dec_legal = 1'b1; end
      3'b101: begin dec_size = 4'd2; dec_legal = 1'b1; end
      // LW only needs extension when the word is narrower than XLEN.
      3'b010: begin dec_size = 4'd4; dec_sgn = (XLEN == 64); dec_legal = 1'b1; end
      3'b011: begin
        if (XLEN == 64) begin dec_size = 4'd8; dec_legal = 1'b1; end
      end
      3'b110: begin
        if (XLEN == 64) begin dec_size = 4'd4; dec_legal = 1'b1; end
      end
      default: ;
    endcase
  end

  assign req_off   = req_addr[OW-1:0];
  assign req_base  = {req_addr[AW-1:OW], {OW{1'b0}}};
  assign req_span  = 5'(req_off) + 5'(dec_size);
  assign req_split = (req_span > 5'(NB));

  // Merge: the incoming beat is combined with the stored low beat so the
  // result can be registered in the same cycle the last beat arrives.
  logic [XLEN-1:0]   beat_lo, beat_hi;
  logic [2*XLEN-1:0] win;
  logic [XLEN-1:0]   merged;
  logic              msb;

  always_comb begin
    beat_lo = (state_q == RD0) ? mem_rdata : lo_q;
    beat_hi = (state_q == RD1) ? mem_rdata : '0;
    win     = {beat_hi, beat_lo} >> {off_q, 3'b000};
    case (size_q)
      4'd1:    msb = win[7];
      4'd2:    msb = win[15];
      4'd4:    msb = win[31];
      default: msb = win[XLEN-1];
    endcase
    merged = '0;
    for (int i = 0; i < NB; i++) begin
      merged[8*i +: 8] = (4'(i) < size_q) ? win[8*i +: 8] : {8{msb & sgn_q}};
    end
  end

  // Next state and state-derived outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = dec_legal ? RD0 : RESP;
      end
      RD0: begin
        mem_rd = 1'b1;
        if (mem_rvalid) state_d = split_q ? RD1 : RESP;
      end
      RD1: begin
        mem_rd = 1'b1;
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      off_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      split_q   <= 1'b0;
      lo_q      <= '0;
      mem_addr  <= '0;
      out_data  <= '0;
      out_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q   <= req_off;
            size_q  <= dec_size;
            sgn_q   <= dec_sgn;
            split_q <= req_split;
            if (dec_legal) begin
              mem_addr <= req_base;
            end else begin
              out_data  <= '0;
              out_fault <= 1'b1;
            end
          end
        end
        RD0: begin
          if (mem_rvalid) begin
            lo_q <= mem_rdata;
            if (split_q) begin
              // Next word; wraps modulo 2^AW by width truncation.
              mem_addr <= mem_addr + AW'(NB);
            end else begin
              out_data  <= merged;
              out_fault <= 1'b0;
            end
          end
        end
        RD1: begin
          if (mem_rvalid) begin
            out_data  <= merged;
            out_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_align_unit.sv
module tb_ld_align_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  mem_rvalid;
  logic [31:0] req_addr0, req_addr1, ir0, ir1;
  logic [31:0] rdata0;
  logic [63:0] rdata1;

  wire [1:0]  req_ready, mem_rd, out_valid, out_fault;
  wire [31:0] mem_addr0, mem_addr1, od32;
  wire [63:0] od64;

  ld_align_unit #(.XLEN(32), .AW(32)) u_dut32 (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr0), .ir(ir0),
    .mem_rd(mem_rd[0]), .mem_addr(mem_addr0),
    .mem_rvalid(mem_rvalid[0]), .mem_rdata(rdata0),
    .out_valid(out_valid[0]), .out_data(od32), .out_fault(out_fault[0])
  );

  ld_align_unit #(.XLEN(64), .AW(32)) u_dut64 (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr1), .ir(ir1),
    .mem_rd(mem_rd[1]), .mem_addr(mem_addr1),
    .mem_rvalid(mem_rvalid[1]), .mem_rdata(rdata1),
    .out_valid(out_valid[1]), .out_data(od64), .out_fault(out_fault[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expectation per out_valid pulse.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (out_valid[0]) begin
      if (q0.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL dut32 unexpected out_valid: got data 0x%0h expected no response", od32);
      end else begin
        e = q0.pop_front();
        chk({e.name, "/data"},  {32'b0, od32}, e.data);
        chk({e.name, "/fault"}, out_fault[0], e.fault);
        chk({e.name, "/cycle"}, cyc, e.cyc);
        chk({e.name, "/req_ready_in_resp"}, req_ready[0], 0);
      end
    end
    if (out_valid[1]) begin
      if (q1.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL dut64 unexpected out_valid: got data 0x%0h expected no response", od64);
      end else begin
        e = q1.pop_front();
        chk({e.name, "/data"},  od64, e.data);
        chk({e.name, "/fault"}, out_fault[1], e.fault);
        chk({e.name, "/cycle"}, cyc, e.cyc);
        chk({e.name, "/req_ready_in_resp"}, req_ready[1], 0);
      end
    end
  end

  task automatic set_req(input int d, input logic [2:0] fn, input logic [31:0] addr);
    if (d == 0) begin
      req_addr0 = addr; ir0 = {17'b0, fn, 12'b0};
    end else begin
      req_addr1 = addr; ir1 = {17'b0, fn, 12'b0};
    end
    req_valid[d] = 1'b1;
  endtask

  task automatic give_beat(input int d, input logic [63:0] b);
    if (d == 0) rdata0 = b[31:0];
    else        rdata1 = b;
    mem_rvalid[d] = 1'b1;
    @(posedge clk); #1;
    mem_rvalid[d] = 1'b0;
  endtask

  // Issue one load; nbeats=0 means an illegal type (no memory access).
  task automatic do_load(input int d, input string name, input logic [2:0] fn,
                         input logic [31:0] addr, input int nbeats,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input int wt, input logic [63:0] edata, input logic efault);
    int acc, lat, guard;
    exp_t e;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk({name, "/req_ready"}, req_ready[d], 1);
    set_req(d, fn, addr);
    acc = cyc;
    lat = (nbeats == 0) ? 1 : (nbeats + 1) + nbeats * wt;
    e.data = edata; e.fault = efault; e.cyc = acc + lat; e.name = name;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      chk($sformatf("%s/mem_rd%0d", name, i), mem_rd[d], 1);
      chk($sformatf("%s/mem_addr%0d", name, i), (d == 0) ? mem_addr0 : mem_addr1, (i == 0) ? a0 : a1);
      for (int w = 0; w < wt; w++) begin
        @(posedge clk); #1;
        chk($sformatf("%s/mem_rd_hold%0d", name, w), mem_rd[d], 1);
        chk($sformatf("%s/req_ready_busy%0d", name, w), req_ready[d], 0);
      end
      give_beat(d, (i == 0) ? b0 : b1);
    end
    chk({name, "/mem_rd_done"}, mem_rd[d], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; mem_rvalid = '0;
    req_addr0 = '0; req_addr1 = '0; ir0 = '0; ir1 = '0;
    rdata0 = '0; rdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/req_ready", req_ready, 2'b11);
    chk("rst/mem_rd", mem_rd, 2'b00);
    chk("rst/out_valid", out_valid, 2'b00);
    chk("rst/out_fault", out_fault, 2'b00);
    chk("rst/out_data32", od32, 0);
    chk("rst/out_data64", od64, 0);
    chk("rst/mem_addr32", mem_addr0, 0);
    chk("rst/mem_addr64", mem_addr1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray mem_rvalid while idle must be ignored.
    rdata0 = 32'hFFFF_FFFF;
    mem_rvalid[0] = 1'b1;
    @(posedge clk); #1;
    mem_rvalid[0] = 1'b0;
    chk("idle_rvalid/mem_rd", mem_rd[0], 0);
    chk("idle_rvalid/req_ready", req_ready[0], 1);

    // XLEN=32 directed loads
    do_load(0, "lb",      3'b000, 32'h103, 1, 32'h100, 32'h0, 64'h8011_2233, 64'h0, 0, 64'hFFFF_FF80, 1'b0);
    do_load(0, "lhu_spl", 3'b101, 32'h103, 2, 32'h100, 32'h104, 64'hAABB_CCDD, 64'h1122_3344, 0, 64'h0000_44AA, 1'b0);
    do_load(0, "lw_wait", 3'b010, 32'h200, 1, 32'h200, 32'h0, 64'hDEAD_BEEF, 64'h0, 2, 64'hDEAD_BEEF, 1'b0);
    do_load(0, "ill_111", 3'b111, 32'h300, 0, 32'h0, 32'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1);
    do_load(0, "ill_011", 3'b011, 32'h300, 0, 32'h0, 32'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1);
    do_load(0, "lh_pos",  3'b001, 32'h101, 1, 32'h100, 32'h0, 64'h0012_7F34, 64'h0, 0, 64'h0000_127F, 1'b0);

    // XLEN=64 directed loads
    do_load(1, "ld_wrap", 3'b011, 32'hFFFF_FFFC, 2, 32'hFFFF_FFF8, 32'h0,
            64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908, 0, 64'h0B0A_0908_0706_0504, 1'b0);
    do_load(1, "lw64",    3'b010, 32'h1004, 1, 32'h1000, 32'h0, 64'h8000_0000_0000_0000, 64'h0, 0,
            64'hFFFF_FFFF_8000_0000, 1'b0);
    do_load(1, "lwu64",   3'b110, 32'h1004, 1, 32'h1000, 32'h0, 64'h8000_0000_0000_0000, 64'h0, 0,
            64'h0000_0000_8000_0000, 1'b0);
    do_load(1, "ill64",   3'b111, 32'h1000, 0, 32'h0, 32'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1);

    // Reset during RD1 of a split LH: no response may appear.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid/req_ready", req_ready[0], 1);
    set_req(0, 3'b001, 32'h103);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("rst_mid/rd0_addr", mem_addr0, 32'h100);
    give_beat(0, 64'h1234_5678);
    chk("rst_mid/rd1_mem_rd", mem_rd[0], 1);
    chk("rst_mid/rd1_addr", mem_addr0, 32'h104);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/mem_rd", mem_rd[0], 0);
    chk("rst_mid/req_ready", req_ready[0], 1);
    chk("rst_mid/out_valid", out_valid[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_load(0, "lh_after_rst", 3'b001, 32'h102, 1, 32'h100, 32'h0, 64'h8001_ABCD, 64'h0, 0, 64'hFFFF_8001, 1'b0);

    repeat (4) @(posedge clk);
    #3;
    chk("drain/q0", q0.size(), 0);
    chk("drain/q1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
